// File: rtl/sha256_host_link.sv
// Host-side link for the byte-serial SHA-256 core: buffer a message, burst it to the
// core without gaps, collect the 32-byte digest and compare it with the expected value.
module sha256_host_link #(
    parameter int unsigned MAX_LEN     = 55,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [7:0]   core_data,
    output logic         core_valid,
    input  logic [7:0]   dig_data,
    input  logic         dig_valid,
    input  logic [255:0] exp_digest,
    output logic [255:0] digest,
    output logic         done,
    output logic         match,
    output logic         err_len,
    output logic         err_timeout,
    output logic         busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StFill, StDrain, StBurst, StWait, StCollect, StDone
    } state_e;

    state_e         state_q, state_d;
    logic [5:0]     count_q, count_d;
    logic [5:0]     idx_q, idx_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           in_ready_q, in_ready_d;
    logic           core_valid_q, core_valid_d;
    logic [7:0]     core_data_q, core_data_d;
    logic [255:0]   digest_q, digest_d;
    logic           done_q, done_d;
    logic           match_q, match_d;
    logic           err_len_q, err_len_d;
    logic           err_timeout_q, err_timeout_d;
    logic [7:0]     msg_q [64];
    logic           wr_en;
    logic [5:0]     wr_addr;
    logic [4:0]     lane;
    logic           accept;

    assign accept = in_valid && in_ready_q;
    assign lane   = 5'd31 - idx_q[4:0];

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        idx_d         = idx_q;
        tcnt_d        = tcnt_q;
        core_valid_d  = 1'b0;
        core_data_d   = core_data_q;
        digest_d      = digest_q;
        done_d        = 1'b0;
        match_d       = match_q;
        err_len_d     = err_len_q;
        err_timeout_d = err_timeout_q;
        wr_en         = 1'b0;
        wr_addr       = count_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    wr_en         = 1'b1;
                    wr_addr       = 6'd0;
                    count_d       = 6'd1;
                    idx_d         = 6'd0;
                    match_d       = 1'b0;
                    err_len_d     = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = in_last ? StBurst : StFill;
                end
            end
            StFill: begin
                if (accept) begin
                    if (count_q == 6'(MAX_LEN)) begin
                        // Overflow byte is dropped; an overlong message never reaches the core.
                        err_len_d = 1'b1;
                        match_d   = 1'b0;
                        state_d   = in_last ? StDone : StDrain;
                        done_d    = in_last;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + 6'd1;
                        if (in_last) state_d = StBurst;
                    end
                end
            end
            StDrain: begin
                if (accept && in_last) begin
                    match_d = 1'b0;
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StBurst: begin
                if (idx_q < count_q) begin
                    core_valid_d = 1'b1;
                    core_data_d  = msg_q[idx_q];
                    idx_d        = idx_q + 6'd1;
                end else begin
                    idx_d   = 6'd0;
                    tcnt_d  = '0;
                    state_d = StWait;
                end
            end
            StWait, StCollect: begin
                if (dig_valid) begin
                    digest_d[{lane, 3'b000} +: 8] = dig_data;
                    idx_d   = idx_q + 6'd1;
                    tcnt_d  = '0;
                    state_d = StCollect;
                    if (idx_q == 6'd31) begin
                        match_d = (digest_d == exp_digest);
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    match_d       = 1'b0;
                    state_d       = StDone;
                    done_d        = 1'b1;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        in_ready_d = (state_d == StIdle) || (state_d == StFill) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            idx_q         <= '0;
            tcnt_q        <= '0;
            in_ready_q    <= 1'b0;
            core_valid_q  <= 1'b0;
            core_data_q   <= '0;
            digest_q      <= '0;
            done_q        <= 1'b0;
            match_q       <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            tcnt_q        <= tcnt_d;
            in_ready_q    <= in_ready_d;
            core_valid_q  <= core_valid_d;
            core_data_q   <= core_data_d;
            digest_q      <= digest_d;
            done_q        <= done_d;
            match_q       <= match_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) msg_q[wr_addr] <= in_data;
    end

    assign in_ready    = in_ready_q;
    assign core_valid  = core_valid_q;
    assign core_data   = core_data_q;
    assign digest      = digest_q;
    assign done        = done_q;
    assign match       = match_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: doc/sha256_host_link.md
Name: sha256_host_link

Overview:
Host-side partner of the byte-serial SHA-256 hash core. It takes a message from an upstream valid/ready byte stream and buffers it completely. It then bursts the message into the core as one contiguous byte+valid run, because the core treats any gap as end-of-message. Finally it collects the 32-byte digest the core streams back, assembles it into a 256-bit word and compares it with an expected digest.

Parameters:
MAX_LEN, 55, maximum message length in bytes per request (single-block padding limit); legal range 1..63
TIMEOUT_CYC, 1023, idle cycles tolerated while waiting for or between digest bytes before aborting

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_data  input  8  message byte from host
in_valid  input  1  in_data valid
in_last  input  1  marks final message byte; qualified by in_valid
in_ready  output  1  block accepts in_data this cycle
core_data  output  8  byte to hash core (core ui)
core_valid  output  1  byte strobe to hash core (core uio[0])
dig_data  input  8  digest byte from hash core (core uo)
dig_valid  input  1  digest byte strobe from hash core (core uio[1])
exp_digest  input  256  expected digest, big-endian (H0 in [255:224])
digest  output  256  collected digest, big-endian
done  output  1  one-cycle pulse: request finished (ok or error)
match  output  1  digest == exp_digest; valid with done, held until next done
err_len  output  1  message exceeded MAX_LEN; valid with done, held
err_timeout  output  1  digest did not arrive within TIMEOUT_CYC; valid with done, held
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; in_ready=0, core_valid=0, core_data=0, digest=0, done=0, match=0, err_len=0, err_timeout=0, busy=0; byte counter and timeout counter at 0. Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, FILL, DRAIN, BURST, WAIT, COLLECT, DONE.
- IDLE: in_ready=1. An accepted byte (in_valid&&in_ready) goes to buf[0], count=1 and clears err_len/err_timeout/match. Then FILL, or BURST directly if in_last.
- FILL: in_ready=1, one byte per cycle into buf[count]. Accepted byte with in_last -> BURST. Accepting byte number MAX_LEN+1 without in_last -> err_len=1 and DRAIN; the overflow byte is discarded.
- DRAIN: in_ready=1, bytes discarded until an in_last byte is accepted -> DONE (match=0, digest unchanged).
- BURST: in_ready=0. core_valid=1 for exactly count consecutive cycles, core_data=buf[0..count-1] in order. core_data and core_valid are registered, so the first byte appears the cycle after entering BURST. After the last byte, core_valid=0 -> WAIT with timeout counter=0.
- WAIT: the first dig_valid byte goes to digest[255:248], idx=1 -> COLLECT. Each non-strobe cycle increments the timeout counter; reaching TIMEOUT_CYC -> err_timeout=1 -> DONE.
- COLLECT: each dig_valid byte goes to digest[255-8*idx -: 8], idx++, timeout counter cleared. Gaps are tolerated and counted as in WAIT. The 32nd byte -> DONE.
- DONE: single cycle. done=1. match is registered from the comparison of the completed digest with exp_digest sampled in this cycle; match is forced to 0 on any error. Then IDLE.
- dig_valid outside WAIT/COLLECT is ignored. in_valid is ignored while in_ready=0.
- Width rules: count is 6 bits, idx is 6 bits, timeout counter is clog2(TIMEOUT_CYC+1) bits and saturates.

Test Plan:
- "abc" (0x61,0x62,0x63, in_last on 0x63) with a core model -> core_valid high exactly 3 consecutive cycles carrying 61,62,63. Digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad with exp_digest equal -> done pulse, match=1, errors 0.
- Same "abc" with exp_digest bit 0 flipped -> done=1, match=0, digest still ba78...15ad.
- Host drives in_valid with random gaps across a 55-byte message -> burst to the core still contiguous, 55 cycles, bytes in order; match=1 against the reference digest.
- 56 bytes with no in_last, then 4 more bytes ending in_last -> err_len=1, core_valid never asserted, done after the in_last byte, match=0.
- Core model never raises dig_valid -> done exactly TIMEOUT_CYC (1023) cycles after the burst ends, err_timeout=1, match=0. Second variant: core stops after 16 digest bytes -> same timeout behaviour.
- reset_n asserted during BURST at byte 10 -> core_valid=0 and busy=0 immediately, no done pulse. A following "abc" request completes with match=1.
